// File: rtl/q2_sequencer.sv
// q2_sequencer -- machine-state sequencer for the Q2 CPU.
//
// Walks each instruction through FETCH, DEREF, LOAD, EXEC (two clocks each,
// phase A then a phase B commit clock with ws=1) and an 8-cycle ALU shift.
// The instruction byte is latched from dbus on the edge that ends FETCH
// phase B. Front-panel run/step gating parks the machine at FETCH phase A.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   run                level: 1 = free-run, 0 = halt at next FETCH
//   step               pulse: while halted, run exactly one instruction
//   dbus[7:0]          instruction byte, sampled at the end of FETCH phase B
//   s0/ns0, s1/ns1     {s1,s0}: 00 FETCH, 01 DEREF, 10 LOAD, 11 EXEC (00 in ALU)
//   s2, s3             ALU shift: s2 on cycles 0-6, s3 on cycle 7
//   ws                 write strobe (commit clock of a state)
//   o0..o2 / no0..no2  latched opcode dbus[7:5] and complements
//   deref              latched indirect bit dbus[4]
//   halted             parked at FETCH phase A waiting for run/step
module q2_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic [7:0] dbus,
   output logic       s0,
   output logic       ns0,
   output logic       s1,
   output logic       ns1,
   output logic       s2,
   output logic       s3,
   output logic       ws,
   output logic       o0,
   output logic       no0,
   output logic       o1,
   output logic       no1,
   output logic       o2,
   output logic       no2,
   output logic       deref,
   output logic       halted
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_DEREF = 3'd1,
      ST_LOAD  = 3'd2,
      ST_EXEC  = 3'd3,
      ST_ALU   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       phase_q, phase_d;        // 0 = phase A, 1 = phase B
   logic [2:0] alu_cnt_q, alu_cnt_d;
   logic [2:0] op_q, op_d;
   logic       deref_q, deref_d;
   logic       pend_q, pend_d;          // one-shot step request
   logic       step_prev_q, step_prev_d;
   logic       halted_q, halted_d;

   logic       step_rise;
   logic       leave_fetch_a;

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      alu_cnt_d     = alu_cnt_q;
      op_d          = op_q;
      deref_d       = deref_q;
      pend_d        = pend_q;
      step_prev_d   = step;
      leave_fetch_a = 1'b0;
      step_rise     = step & ~step_prev_q;

      case (state_q)
         ST_FETCH: begin
            if (!phase_q) begin
               if (run || pend_q) begin
                  phase_d       = 1'b1;
                  leave_fetch_a = 1'b1;
               end
            end else begin
               // Exit decision uses the bits being latched on this edge.
               op_d    = dbus[7:5];
               deref_d = dbus[4];
               phase_d = 1'b0;
               if (dbus[4])      state_d = ST_DEREF;
               else if (!dbus[7]) state_d = ST_LOAD;
               else              state_d = ST_EXEC;
            end
         end
         ST_DEREF: begin
            if (!phase_q) phase_d = 1'b1;
            else begin
               phase_d = 1'b0;
               state_d = op_q[2] ? ST_EXEC : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!phase_q) phase_d = 1'b1;
            else begin
               phase_d = 1'b0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!phase_q) phase_d = 1'b1;
            else begin
               phase_d   = 1'b0;
               alu_cnt_d = 3'd0;
               state_d   = op_q[2] ? ST_FETCH : ST_ALU;
            end
         end
         ST_ALU: begin
            if (alu_cnt_q == 3'd7) begin
               alu_cnt_d = 3'd0;
               state_d   = ST_FETCH;
            end else begin
               alu_cnt_d = alu_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d   = ST_FETCH;
            phase_d   = 1'b0;
            alu_cnt_d = 3'd0;
         end
      endcase

      // Pending step: consumed when FETCH A is left, armed by a fresh rising
      // edge of step while halting, and overridden by run.
      if (leave_fetch_a)      pend_d = 1'b0;
      if (step_rise && !run)  pend_d = 1'b1;
      if (run)                pend_d = 1'b0;

      halted_d = (state_d == ST_FETCH) && !phase_d && !run && !pend_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FETCH;
         phase_q     <= 1'b0;
         alu_cnt_q   <= 3'd0;
         op_q        <= 3'd0;
         deref_q     <= 1'b0;
         pend_q      <= 1'b0;
         step_prev_q <= step;
         halted_q    <= !run;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         alu_cnt_q   <= alu_cnt_d;
         op_q        <= op_d;
         deref_q     <= deref_d;
         pend_q      <= pend_d;
         step_prev_q <= step_prev_d;
         halted_q    <= halted_d;
      end
   end

   // Outputs decode only flop state, so there is no path from the inputs.
   assign s0     = (state_q == ST_DEREF) || (state_q == ST_EXEC);
   assign s1     = (state_q == ST_LOAD)  || (state_q == ST_EXEC);
   assign s2     = (state_q == ST_ALU) && (alu_cnt_q != 3'd7);
   assign s3     = (state_q == ST_ALU) && (alu_cnt_q == 3'd7);
   assign ws     = (state_q == ST_ALU) ? (alu_cnt_q == 3'd7) : phase_q;
   assign ns0    = ~s0;
   assign ns1    = ~s1;
   assign o0     = op_q[0];
   assign o1     = op_q[1];
   assign o2     = op_q[2];
   assign no0    = ~op_q[0];
   assign no1    = ~op_q[1];
   assign no2    = ~op_q[2];
   assign deref  = deref_q;
   assign halted = halted_q;

endmodule
